sldma230_cfg_seq: RTL and testbench



---
 rtl/sldma230_cfg_seq.sv | 223 ++++++++++++++++++++++
 tb/tb_sldma230_cfg_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sldma230_cfg_seq.sv
// APB-master sequencer that programs one SLDMA-230 channel, waits for done/error/timeout, cleans up on failure, then reports.
// All outputs registered; each APB phase holds while PCLKEN is low, and START is only sampled in IDLE.
module sldma230_cfg_seq #(
  parameter int CFG_ADDR_W  = 12,
  parameter int SYS_DATA_W  = 32,
  parameter int CHANNEL_NUM = 2,
  parameter int CHAN_W      = 1,
  parameter int TIMEOUT_CYC = 65535,
  parameter int TO_W        = 16
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic                   START,
  input  logic [CHAN_W-1:0]      CHAN,
  input  logic [SYS_DATA_W-1:0]  CTRL_BASE,
  output logic                   BUSY,
  output logic                   DONE,
  output logic                   ERR,
  output logic                   TIMEOUT,
  input  logic                   PCLKEN,
  output logic                   PSEL,
  output logic                   PEN,
  output logic                   PWRITE,
  output logic [CFG_ADDR_W-1:0]  PADDR,
  output logic [SYS_DATA_W-1:0]  PWDATA,
  input  logic [CHANNEL_NUM-1:0] DMA_DONE,
  input  logic                   DMA_ERR
);

  localparam int NSEL = 1 << CHAN_W;
  localparam logic [TO_W-1:0] TO_LIM = TO_W'(TIMEOUT_CYC);
  localparam logic [SYS_DATA_W-1:0] BASE_MASK = ~SYS_DATA_W'(32'hFF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT,
    ST_REPORT
  } state_t;

  typedef enum logic [1:0] {
    C_NONE,
    C_DONE,
    C_ERR,
    C_TO
  } cause_t;

  state_t                  state;
  state_t                  state_nxt;
  cause_t                  cause;
  cause_t                  cause_nxt;
  logic [2:0]              widx;
  logic [2:0]              widx_nxt;
  logic [CHAN_W-1:0]       chan_q;
  logic [CHAN_W-1:0]       chan_nxt;
  logic [SYS_DATA_W-1:0]   base_q;
  logic [SYS_DATA_W-1:0]   base_nxt;
  logic [TO_W-1:0]         cnt;
  logic [TO_W-1:0]         cnt_nxt;
  logic [TO_W-1:0]         cnt_inc;
  logic [NSEL-1:0]         done_vec;
  logic                    chan_done;
  logic                    limit_hit;
  logic                    apb_on;
  logic [SYS_DATA_W-1:0]   chan_bit;
  logic [CFG_ADDR_W-1:0]   addr_nxt;
  logic [SYS_DATA_W-1:0]   data_nxt;

  // Pad DMA_DONE to the full index range so any CHAN value selects a defined bit.
  always_comb begin
    done_vec = '0;
    done_vec[CHANNEL_NUM-1:0] = DMA_DONE;
    chan_done = done_vec[chan_q];
  end

  always_comb begin
    cnt_inc   = (cnt == TO_LIM) ? cnt : cnt + TO_W'(1);
    limit_hit = (TIMEOUT_CYC != 0) && (cnt_inc == TO_LIM);
    chan_bit  = SYS_DATA_W'(1) << chan_q;
  end

  always_comb begin
    state_nxt = state;
    cause_nxt = cause;
    widx_nxt  = widx;
    chan_nxt  = chan_q;
    base_nxt  = base_q;
    cnt_nxt   = cnt;
    unique case (state)
      ST_IDLE: begin
        if (START) begin
          state_nxt = ST_SETUP;
          widx_nxt  = 3'd0;
          chan_nxt  = CHAN;
          base_nxt  = CTRL_BASE & BASE_MASK;
          cause_nxt = C_NONE;
        end
      end
      ST_SETUP: begin
        if (PCLKEN) begin
          state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (PCLKEN) begin
          case (widx)
            3'd0, 3'd1, 3'd2: begin
              state_nxt = ST_SETUP;
              widx_nxt  = widx + 3'd1;
            end
            3'd3: begin
              state_nxt = ST_WAIT;
              cnt_nxt   = '0;
            end
            3'd4: begin
              state_nxt = ST_SETUP;
              widx_nxt  = 3'd5;
            end
            default: begin
              state_nxt = ST_REPORT;
            end
          endcase
        end
      end
      ST_WAIT: begin
        cnt_nxt = cnt_inc;
        if (DMA_ERR) begin
          state_nxt = ST_SETUP;
          widx_nxt  = 3'd4;
          cause_nxt = C_ERR;
        end else if (chan_done) begin
          state_nxt = ST_REPORT;
          cause_nxt = C_DONE;
        end else if (limit_hit) begin
          state_nxt = ST_SETUP;
          widx_nxt  = 3'd4;
          cause_nxt = C_TO;
        end
      end
      ST_REPORT: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address/data decode looks at the upcoming write so the registered bus is valid in the first SETUP cycle.
  always_comb begin
    apb_on = (state_nxt == ST_SETUP) || (state_nxt == ST_ACCESS);
    case (widx_nxt)
      3'd0: begin
        addr_nxt = CFG_ADDR_W'(12'h004);
        data_nxt = SYS_DATA_W'(1);
      end
      3'd1: begin
        addr_nxt = CFG_ADDR_W'(12'h008);
        data_nxt = base_q;
      end
      3'd2: begin
        addr_nxt = CFG_ADDR_W'(12'h028);
        data_nxt = chan_bit;
      end
      3'd3: begin
        addr_nxt = CFG_ADDR_W'(12'h014);
        data_nxt = chan_bit;
      end
      3'd4: begin
        addr_nxt = CFG_ADDR_W'(12'h02C);
        data_nxt = chan_bit;
      end
      default: begin
        addr_nxt = CFG_ADDR_W'(12'h04C);
        data_nxt = SYS_DATA_W'(1);
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state  <= ST_IDLE;
      cause  <= C_NONE;
      widx   <= '0;
      chan_q <= '0;
      base_q <= '0;
      cnt    <= '0;
    end else begin
      state  <= state_nxt;
      cause  <= cause_nxt;
      widx   <= widx_nxt;
      chan_q <= chan_nxt;
      base_q <= base_nxt;
      cnt    <= cnt_nxt;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      ERR     <= 1'b0;
      TIMEOUT <= 1'b0;
      PSEL    <= 1'b0;
      PEN     <= 1'b0;
      PWRITE  <= 1'b0;
      PADDR   <= '0;
      PWDATA  <= '0;
    end else begin
      BUSY    <= (state_nxt != ST_IDLE);
      DONE    <= (state_nxt == ST_REPORT) && (cause_nxt == C_DONE);
      ERR     <= (state_nxt == ST_REPORT) && (cause_nxt == C_ERR);
      TIMEOUT <= (state_nxt == ST_REPORT) && (cause_nxt == C_TO);
      PSEL    <= apb_on;
      PEN     <= (state_nxt == ST_ACCESS);
      PWRITE  <= apb_on;
      PADDR   <= apb_on ? addr_nxt : '0;
      PWDATA  <= apb_on ? data_nxt : '0;
    end
  end

endmodule

// File: tb/tb_sldma230_cfg_seq.sv
// Randomized scoreboard bench for sldma230_cfg_seq: the driver pushes each run's expected APB writes and report pulse,
// a negedge monitor pops and compares whenever a write completes or a pulse appears.
module tb_sldma230_cfg_seq;

  localparam int T = 10;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        START = 1'b0;
  logic        CHAN = 1'b0;
  logic [31:0] CTRL_BASE = '0;
  logic        BUSY;
  logic        DONE;
  logic        ERR;
  logic        TIMEOUT;
  logic        PCLKEN = 1'b1;
  logic        PSEL;
  logic        PEN;
  logic        PWRITE;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic [1:0]  DMA_DONE = '0;
  logic        DMA_ERR = 1'b0;

  sldma230_cfg_seq #(
    .CFG_ADDR_W(12), .SYS_DATA_W(32), .CHANNEL_NUM(2), .CHAN_W(1),
    .TIMEOUT_CYC(T), .TO_W(16)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .START(START), .CHAN(CHAN), .CTRL_BASE(CTRL_BASE),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .TIMEOUT(TIMEOUT), .PCLKEN(PCLKEN),
    .PSEL(PSEL), .PEN(PEN), .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA),
    .DMA_DONE(DMA_DONE), .DMA_ERR(DMA_ERR)
  );

  always #5 HCLK = ~HCLK;

  // kind: 0 = APB write, 1 = DONE, 2 = ERR, 3 = TIMEOUT
  typedef struct packed {
    logic [1:0]  kind;
    logic [11:0] addr;
    logic [31:0] data;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  cyc = 0;
  int  mode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic pulse();
    return DONE | ERR | TIMEOUT;
  endfunction

  function automatic logic in_wait();
    return BUSY && !PSEL && !pulse();
  endfunction

  task automatic tick();
    @(posedge HCLK);
    #1;
    cyc++;
    case (mode)
      0:       PCLKEN = 1'b1;
      1:       PCLKEN = (cyc % 3 == 0);
      default: PCLKEN = 1'($urandom_range(0, 1));
    endcase
  endtask

  task automatic push(input logic [1:0] k, input logic [11:0] a, input logic [31:0] dt);
    ev_t e;
    e.kind = k;
    e.addr = a;
    e.data = dt;
    exp_q.push_back(e);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ctl"}, 64'({BUSY, DONE, ERR, TIMEOUT, PSEL, PEN, PWRITE}), 64'(0));
    chk({tag, "_bus"}, 64'({PADDR, PWDATA}), 64'(0));
  endtask

  task automatic recover(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired at cycle %0d, required DUT progress", name, cyc);
    HRESET = 1'b1;
    START = 1'b0;
    DMA_DONE = '0;
    DMA_ERR = 1'b0;
    tick();
    tick();
    HRESET = 1'b0;
    exp_q.delete();
  endtask

  // ev: 1 = DMA_DONE[chan], 2 = DMA_ERR, 3 = nothing; delivered in WAIT cycle d (0-based) if still waiting.
  task automatic run_seq(input int chan, input logic [31:0] base, input int ev, input int d,
                         input int md, input bit both, input bit chain, input bit do_reset);
    int res, exp_wlen, wlen, n, wdone;
    bit comp;
    logic [31:0] cb;
    mode = md;
    cb = 32'd1 << chan;
    res = (ev != 3 && d < T) ? ev : 3;
    exp_wlen = (res == 3) ? T : d + 1;
    push(2'd0, 12'h004, 32'd1);
    push(2'd0, 12'h008, base & ~32'hFF);
    push(2'd0, 12'h028, cb);
    push(2'd0, 12'h014, cb);
    if (res != 1) begin
      push(2'd0, 12'h02C, cb);
      push(2'd0, 12'h04C, 32'd1);
    end
    push(2'(res), 12'h0, 32'h0);

    chk("idle_before_start", 64'(BUSY), 64'(0));
    START = 1'b1;
    CHAN = 1'(chan);
    CTRL_BASE = base;
    tick();
    chk("start_latency", 64'({BUSY, PSEL, PEN}), 64'(3'b110));

    n = 0;
    wdone = 0;
    while (!in_wait()) begin
      if (do_reset && PSEL && PEN && wdone == 2) begin
        HRESET = 1'b1;
        START = 1'b0;
        tick();
        HRESET = 1'b0;
        check_reset_vals("reset_mid_access");
        exp_q.delete();
        return;
      end
      comp = PSEL && PEN && PCLKEN;
      CHAN = 1'($urandom);
      CTRL_BASE = $urandom;
      DMA_DONE = 2'($urandom);
      DMA_ERR = 1'($urandom);
      tick();
      n++;
      if (comp) wdone++;
      if (n > 300) begin
        recover("setup_bound");
        return;
      end
    end
    if (md == 0) chk("write_cycles", 64'(n), 64'(8));

    wlen = 0;
    while (in_wait()) begin
      DMA_ERR = 1'b0;
      DMA_DONE = 2'($urandom) & ~2'(cb);
      if (ev != 3 && wlen == d) begin
        if (ev == 1) begin
          DMA_DONE[chan] = 1'b1;
        end else begin
          DMA_ERR = 1'b1;
          if (both) DMA_DONE[chan] = 1'b1;
        end
      end
      CHAN = 1'($urandom);
      CTRL_BASE = $urandom;
      tick();
      wlen++;
      if (wlen > T + 5) begin
        recover("wait_bound");
        return;
      end
    end
    chk("wait_len", 64'(wlen), 64'(exp_wlen));
    if (res == 1) chk("done_latency", 64'(DONE), 64'(1));

    n = 0;
    while (!pulse()) begin
      DMA_DONE = 2'($urandom);
      DMA_ERR = 1'($urandom);
      CHAN = 1'($urandom);
      CTRL_BASE = $urandom;
      tick();
      n++;
      if (n > 300) begin
        recover("report_bound");
        return;
      end
    end
    if (res != 1 && md == 0) chk("cleanup_cycles", 64'(n), 64'(4));

    START = chain;
    DMA_DONE = 2'($urandom);
    DMA_ERR = 1'($urandom);
    tick();
    chk("busy_after_report", 64'({BUSY, PSEL, pulse()}), 64'(0));
  endtask

  // Scoreboard monitor plus bus invariants, sampled mid-cycle.
  initial begin
    ev_t         e;
    logic [11:0] pa;
    logic [31:0] pd;
    logic        phold;
    logic [1:0]  k;
    phold = 1'b0;
    pa = '0;
    pd = '0;
    forever begin
      @(negedge HCLK);
      if (HRESET) begin
        phold = 1'b0;
      end else begin
        if (PSEL && PEN && PCLKEN) begin
          chk("pwrite_high", 64'(PWRITE), 64'(1));
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", PADDR, PWDATA);
          end else begin
            e = exp_q.pop_front();
            chk("apb_write", 64'({2'd0, PADDR, PWDATA}), 64'(e));
          end
        end
        if (pulse()) begin
          chk("pulse_onehot", 64'($countones({DONE, ERR, TIMEOUT})), 64'(1));
          k = DONE ? 2'd1 : (ERR ? 2'd2 : 2'd3);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: got kind %0d, expected none", k);
          end else begin
            e = exp_q.pop_front();
            chk("report_pulse", 64'({k, 12'h0, 32'h0}), 64'(e));
          end
        end
        if (!PSEL) begin
          chk("idle_bus_zero", 64'({PEN, PADDR, PWDATA}), 64'(0));
        end else if (phold) begin
          chk("bus_stable", 64'({PADDR, PWDATA}), 64'({pa, pd}));
        end
        pa = PADDR;
        pd = PWDATA;
        phold = PSEL && !(PEN && PCLKEN);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ch;
    HRESET = 1'b1;
    mode = 0;
    repeat (3) tick();
    HRESET = 1'b0;
    check_reset_vals("reset_state");
    tick();

    run_seq(1, 32'h2000_01FF, 1, 2, 0, 1'b0, 1'b0, 1'b0);
    tick();
    run_seq(1, 32'h1234_5678, 1, 4, 1, 1'b0, 1'b0, 1'b0);
    tick();
    run_seq(0, 32'hFFFF_FFFF, 2, 1, 0, 1'b1, 1'b0, 1'b0);
    tick();
    run_seq(1, 32'h8000_00AA, 3, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    run_seq(0, 32'h0000_0100, 1, T - 1, 0, 1'b0, 1'b0, 1'b0);
    run_seq(1, 32'hCAFE_F00D, 2, T - 1, 2, 1'b0, 1'b1, 1'b0);
    run_seq(0, 32'h0BAD_BEEF, 1, 3, 0, 1'b0, 1'b1, 1'b0);
    run_seq(1, 32'h5555_AAAA, 1, 0, 0, 1'b0, 1'b0, 1'b0);
    tick();
    run_seq(1, 32'h7000_0123, 1, 2, 0, 1'b0, 1'b0, 1'b1);
    run_seq(0, 32'h7000_0456, 1, 2, 0, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      ch = ($urandom_range(0, 3) == 0);
      START = 1'b0;
      run_seq($urandom_range(0, 1), $urandom, $urandom_range(1, 3), $urandom_range(0, T + 2),
              $urandom_range(0, 2), 1'($urandom), ch, ($urandom_range(0, 9) == 0));
      if (!ch) begin
        START = 1'b0;
        DMA_DONE = '0;
        DMA_ERR = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
    end

    START = 1'b0;
    DMA_DONE = '0;
    DMA_ERR = 1'b0;
    repeat (4) tick();
    chk("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
